// File: rtl/distortion_pkg.sv
// Shared constants and control-clamping helpers for the distortion processor.
package distortion_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_GAIN   = 2'd1;
    localparam logic [1:0] MODE_CLIP   = 2'd2;
    localparam logic [1:0] MODE_DRIVE  = 2'd3;

    localparam int SAMPLE_MAX = 32767;
    localparam int THRESH_MAX = 32767;

    // Gains below 1 would mute or invert the signal; there is no upper bound.
    function automatic logic signed [15:0] clamp_gain(input logic signed [15:0] g);
        return (g < 16'sd1) ? 16'sd1 : g;
    endfunction

    function automatic logic signed [31:0] clamp_thresh(input logic signed [31:0] t);
        logic signed [31:0] r;
        r = t;
        if (t < 0)
            r = 0;
        else if (t > THRESH_MAX)
            r = THRESH_MAX;
        return r;
    endfunction

endpackage

// File: rtl/distortion_clipper.sv
// Symmetric clamp of a 32-bit value to -limit..+limit; reports whether the value changed.
module distortion_clipper (
    input  logic [31:0] value,
    input  logic [31:0] limit,
    output logic [15:0] result,
    output logic        clipped
);
    logic signed [31:0] value_s;
    logic signed [31:0] limit_s;
    logic signed [31:0] neg_limit;

    assign value_s   = $signed(value);
    assign limit_s   = $signed(limit);
    assign neg_limit = -limit_s;

    // Equality with the limit passes through unchanged and is not a clip.
    always_comb begin
        result  = value_s[15:0];
        clipped = 1'b0;
        if (value_s > limit_s) begin
            result  = limit_s[15:0];
            clipped = 1'b1;
        end else if (value_s < neg_limit) begin
            result  = neg_limit[15:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/distortion_processor.sv
// Two-stage distortion pipeline: stage 1 captures sample and controls, stage 2 clamps and
// registers the output; a hold counter keeps clip_led lit for HOLD_SAMPLES outputs.
module distortion_processor
    import distortion_pkg::*;
#(
    parameter int HOLD_SAMPLES = 4800
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] sample_in,
    input  logic        in_valid,
    input  logic [15:0] gainNum,
    input  logic [31:0] threshold,
    input  logic [1:0]  mode,
    output logic [15:0] sample_out,
    output logic        out_valid,
    output logic        clip_led
);
    localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);

    logic               s1_valid;
    logic signed [15:0] s1_sample;
    logic signed [15:0] s1_gain;
    logic signed [31:0] s1_thr;
    logic [1:0]         s1_mode;

    logic signed [31:0] product;
    logic signed [31:0] clip_value;
    logic signed [31:0] clip_limit;
    logic [15:0]        clip_result;
    logic               clip_hit;
    logic [15:0]        stage_result;
    logic               stage_clipped;
    logic [CNT_W-1:0]   hold_count;

    // Controls are frozen with the sample so later changes cannot leak into it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_gain   <= 16'sd1;
            s1_thr    <= '0;
            s1_mode   <= MODE_BYPASS;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sample <= $signed(sample_in);
                s1_gain   <= clamp_gain($signed(gainNum));
                s1_thr    <= clamp_thresh($signed(threshold));
                s1_mode   <= mode;
            end
        end
    end

    // A 16x16 signed product always fits in 32 bits.
    assign product = 32'(s1_sample) * 32'(s1_gain);

    always_comb begin
        clip_value = 32'(s1_sample);
        clip_limit = s1_thr;
        if (s1_mode == MODE_GAIN || s1_mode == MODE_DRIVE)
            clip_value = product;
        if (s1_mode == MODE_GAIN)
            clip_limit = SAMPLE_MAX;
    end

    distortion_clipper u_clipper (
        .value   (clip_value),
        .limit   (clip_limit),
        .result  (clip_result),
        .clipped (clip_hit)
    );

    // Bypass skips the clamp so even -32768 passes through untouched.
    always_comb begin
        stage_result  = clip_result;
        stage_clipped = clip_hit;
        if (s1_mode == MODE_BYPASS) begin
            stage_result  = s1_sample;
            stage_clipped = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid  <= 1'b0;
            sample_out <= '0;
            hold_count <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sample_out <= stage_result;
                if (stage_clipped)
                    hold_count <= CNT_W'(HOLD_SAMPLES);
                else if (hold_count != '0)
                    hold_count <= hold_count - CNT_W'(1);
            end
        end
    end

    assign clip_led = (hold_count != '0);

endmodule

// File: doc/distortion_processor.md
DISTORTION_PROCESSOR -- requirements
Module: distortion_processor

Interface
REQ-001 The block SHALL have parameter HOLD_SAMPLES, default 4800: number of output samples clip_led stays lit after a clip event.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on posedge CLK.
REQ-003 The block SHALL have port RST  input  1  reset; asynchronous and active-high.
REQ-004 The block SHALL have port sample_in  input  16  signed audio sample.
REQ-005 The block SHALL have port in_valid  input  1  one-cycle strobe; sample_in is valid this cycle.
REQ-006 The block SHALL have port gainNum  input  16  signed gain from the distortion controller (1..50 nominal).
REQ-007 The block SHALL have port threshold  input  32  signed clip level from the distortion controller (500..32000 nominal).
REQ-008 The block SHALL have port mode  input  2  effect mode from the distortion controller.
REQ-009 The block SHALL have port sample_out  output  16  signed processed sample.
REQ-010 The block SHALL have port out_valid  output  1  one-cycle strobe; sample_out is new this cycle.
REQ-011 The block SHALL have port clip_led  output  1  clip indicator.

Function
REQ-012 The block SHALL capture sample_in, gainNum, threshold and mode together in stage 1 on a cycle with in_valid=1; later control changes SHALL NOT affect that sample.
REQ-013 The block SHALL assert out_valid exactly 2 cycles after the accepting in_valid, for exactly one cycle per accepted sample.
REQ-014 The block SHALL accept in_valid on consecutive cycles with no loss and no reordering.
REQ-015 The block SHALL hold sample_out unchanged between out_valid pulses.
REQ-016 The block SHALL clamp the captured gain to 1 when gainNum < 1, with no upper clamp.
REQ-017 The block SHALL clamp the captured threshold to 0..32767.
REQ-018 The block SHALL form stage-1 product P = sample * gain as a 32-bit signed value; the width is sufficient, so no overflow occurs.
REQ-019 In mode 0 (bypass) the block SHALL make sample_out equal the captured sample, ignoring gain and threshold.
REQ-020 In mode 1 (gain) the block SHALL make sample_out equal P saturated to -32767..+32767.
REQ-021 In mode 2 (clip) the block SHALL make sample_out equal the captured sample clamped to -thr..+thr, with gain ignored.
REQ-022 In mode 3 (drive) the block SHALL make sample_out equal P clamped to -thr..+thr.
REQ-023 The block SHALL mark a sample clipped when saturation or clamping changed its value; the boundary value itself (|x| == limit) SHALL NOT count as clipped.
REQ-024 On out_valid with a clipped sample, the block SHALL load the hold counter with HOLD_SAMPLES.
REQ-025 On out_valid with an unclipped sample and counter > 0, the block SHALL decrement the counter; the counter SHALL never wrap below 0.
REQ-026 The block SHALL drive clip_led high exactly while the hold counter is non-zero.
REQ-027 In mode 0 the block SHALL never mark a sample clipped.

Reset
REQ-028 While RST=1 the block SHALL force sample_out=0, out_valid=0, clip_led=0, hold counter=0 and all pipeline valid bits=0, with immediate (asynchronous) effect.
REQ-029 The block SHALL discard samples in flight at reset; no out_valid SHALL be produced for them after RST deasserts.
REQ-030 The block SHALL accept a new sample on the first posedge CLK with RST=0 and in_valid=1.

Structure
REQ-031 Package distortion_pkg SHALL hold the mode constants MODE_BYPASS=0, MODE_GAIN=1, MODE_CLIP=2, MODE_DRIVE=3, plus SAMPLE_MAX=32767 and THRESH_MAX=32767.
REQ-032 The block SHALL place the symmetric clamp logic (32-bit value and limit in; clamped 16-bit value and clipped flag out) in a combinational sub-module distortion_clipper, instantiated once in stage 2.

Verification
REQ-033 The bench SHALL check: mode 0, sample_in=-12345 with gain 50 -> sample_out=-12345 two cycles later, clip_led=0.
REQ-034 The bench SHALL check: mode 1, gain 3, sample_in=20000 -> 32767, clipped; gain 3, sample_in=-1000 -> -3000, not clipped.
REQ-035 The bench SHALL check: mode 3, gain 10, thr 16000, inputs 1000/2000/-1700 on consecutive cycles -> 10000/16000/-16000 on three consecutive out_valid cycles.
REQ-036 The bench SHALL check: mode 2, thr 500, sample_in=500 -> 500 with no clip; thr 500, sample_in=501 -> 500, clip_led high; HOLD_SAMPLES=4, then 4 unclipped samples -> clip_led low after the 4th out_valid.
REQ-037 The bench SHALL check: gainNum=0 or -5 in mode 1 -> treated as gain 1; threshold=40000 in mode 2 with sample_in=32767 -> 32767, not clipped.
REQ-038 The bench SHALL check: RST asserted one cycle after in_valid -> no out_valid afterwards, all outputs 0 during reset; mode/gain changed the cycle after in_valid -> result uses the captured values.
